// File: rtl/bcd4digit_to_bin.sv
// ============================================================================
// Module      : bcd4digit_to_bin
// Description : Sequential four-digit BCD to 14-bit binary converter. Digits
//               use the display format (A = ones .. D = thousands, 4'hF =
//               blank). One multiply-by-ten-and-add step per clock, most
//               significant digit first, under a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd4digit_to_bin (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  A,
    input  logic [3:0]  B,
    input  logic [3:0]  C,
    input  logic [3:0]  D,
    output logic [13:0] value,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0]  c_BLANK      = 4'hF;
    localparam logic [3:0]  c_MAX_DIGIT  = 4'd9;
    localparam logic [1:0]  c_FIRST_IX   = 2'd3;
    localparam logic [1:0]  c_LAST_IX    = 2'd0;
    localparam logic [13:0] c_ZERO_VALUE = 14'd0;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_dig_a;
    logic [3:0]  r_dig_b;
    logic [3:0]  r_dig_c;
    logic [3:0]  r_dig_d;
    logic [13:0] r_acc;
    logic [1:0]  r_ix;
    logic        r_bad;
    logic [13:0] r_value;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    // ------------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------------
    logic [3:0]  w_dig;
    logic [3:0]  w_dig_add;
    logic [13:0] w_acc_x10;
    logic [13:0] w_acc_next;
    logic        w_start_bad;

    // Digit codes 4'hA..4'hE are not BCD; 4'hF is a legal blank.
    function automatic logic is_invalid(input logic [3:0] d);
        return (d > c_MAX_DIGIT) && (d != c_BLANK);
    endfunction

    // Inspect the live inputs so the bad flag is captured together with the
    // digit latches on the accepting edge.
    assign w_start_bad = is_invalid(A) | is_invalid(B) |
                         is_invalid(C) | is_invalid(D);

    // Select the latched digit for the current step (thousands first).
    always_comb begin
        w_dig = 4'd0;
        case (r_ix)
            2'd3:    w_dig = r_dig_d;
            2'd2:    w_dig = r_dig_c;
            2'd1:    w_dig = r_dig_b;
            default: w_dig = r_dig_a;
        endcase
    end

    // Blanks and invalid codes both contribute zero; invalid results are
    // zeroed at completion via the bad flag.
    assign w_dig_add = (w_dig <= c_MAX_DIGIT) ? w_dig : 4'd0;

    // acc*10 as shift-and-add; 999*10+9 fits comfortably in 14 bits.
    assign w_acc_x10  = (r_acc << 3) + (r_acc << 1);
    assign w_acc_next = w_acc_x10 + {10'd0, w_dig_add};

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_dig_a <= 4'd0;
            r_dig_b <= 4'd0;
            r_dig_c <= 4'd0;
            r_dig_d <= 4'd0;
            r_acc   <= 14'd0;
            r_ix    <= 2'd0;
            r_bad   <= 1'b0;
            r_value <= c_ZERO_VALUE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only completion re-asserts it.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_dig_a <= A;
                        r_dig_b <= B;
                        r_dig_c <= C;
                        r_dig_d <= D;
                        r_bad   <= w_start_bad;
                        r_acc   <= 14'd0;
                        r_ix    <= c_FIRST_IX;
                        r_busy  <= 1'b1;
                        r_state <= ST_CONV;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    r_acc <= w_acc_next;
                    r_ix  <= r_ix - 2'd1;
                    if (r_ix == c_LAST_IX) begin
                        r_value <= r_bad ? c_ZERO_VALUE : w_acc_next;
                        r_error <= r_bad;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign value = r_value;
    assign busy  = r_busy;
    assign done  = r_done;
    assign error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_bcd4digit_to_bin.sv
// ============================================================================
// Module      : tb_bcd4digit_to_bin
// Description : Directed self-checking bench for bcd4digit_to_bin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd4digit_to_bin;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  A;
    logic [3:0]  B;
    logic [3:0]  C;
    logic [3:0]  D;
    logic [13:0] value;
    logic        busy;
    logic        done;
    logic        error;

    int checks;
    int errors;

    bcd4digit_to_bin dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .value (value),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present digits and pulse start for one edge; returns at the negedge
    // after the accepting edge.
    task automatic start_conv(input logic [3:0] d, input logic [3:0] c,
                              input logic [3:0] b, input logic [3:0] a);
        @(negedge clk);
        D = d; C = c; B = b; A = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy cycles until busy drops (bounded).
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; A = 4'd0; B = 4'd0; C = 4'd0; D = 4'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (value !== 14'd0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset: value=%0d busy=%b done=%b error=%b, expected 0 0 0 0",
                     value, busy, done, error);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        int n;
        start_conv(4'd1, 4'd2, 4'd3, 4'd4);
        wait_idle(n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d expected 4", n);
        end
        checks++;
        if (done !== 1'b1 || value !== 14'h04D2 || error !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: done=%b value=%0d error=%b, expected 1 1234 0",
                     done, value, error);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || value !== 14'h04D2) begin
            errors++;
            $display("FAIL basic_pulse_width: done=%b value=%0d, expected 0 1234", done, value);
        end
    endtask

    task automatic test_patterns;
        logic [15:0] digs [4];
        logic [13:0] exp_v [4];
        int n;
        digs[0] = 16'h9999; exp_v[0] = 14'd9999;
        digs[1] = 16'h0000; exp_v[1] = 14'd0;
        digs[2] = 16'hFFF5; exp_v[2] = 14'd5;
        digs[3] = 16'hF3F7; exp_v[3] = 14'd307;
        for (int i = 0; i < 4; i++) begin
            start_conv(digs[i][15:12], digs[i][11:8], digs[i][7:4], digs[i][3:0]);
            wait_idle(n);
            checks++;
            if (done !== 1'b1 || value !== exp_v[i] || error !== 1'b0 || n !== 4) begin
                errors++;
                $display("FAIL pattern_%h: done=%b value=%0d error=%b lat=%0d, expected 1 %0d 0 4",
                         digs[i], done, value, error, n, exp_v[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_invalid;
        int n;
        start_conv(4'd1, 4'hB, 4'd1, 4'd1);
        wait_idle(n);
        checks++;
        if (done !== 1'b1 || value !== 14'd0 || error !== 1'b1) begin
            errors++;
            $display("FAIL invalid_digit: done=%b value=%0d error=%b, expected 1 0 1",
                     done, value, error);
        end
        start_conv(4'd0, 4'd0, 4'd4, 4'd2);
        checks++;
        if (error !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL error_held: error=%b busy=%b, expected 1 1", error, busy);
        end
        wait_idle(n);
        checks++;
        if (done !== 1'b1 || value !== 14'd42 || error !== 1'b0) begin
            errors++;
            $display("FAIL after_invalid: done=%b value=%0d error=%b, expected 1 42 0",
                     done, value, error);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        int pulses;
        start_conv(4'd5, 4'd6, 4'd7, 4'd8);
        // Re-pulse start and scramble inputs during the conversion.
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            D = 4'd9; C = 4'd9; B = 4'd9; A = 4'd9;
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || value !== 14'd5678) begin
            errors++;
            $display("FAIL start_while_busy: done=%b value=%0d, expected 1 5678", done, value);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL no_extra_done: got %0d active cycles expected 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int gap;
        start_conv(4'd0, 4'd0, 4'd1, 4'd2);
        wait_idle(n);
        checks++;
        if (done !== 1'b1 || value !== 14'd12) begin
            errors++;
            $display("FAIL b2b_first: done=%b value=%0d, expected 1 12", done, value);
        end
        // Hold start through the DONE cycle.
        D = 4'd0; C = 4'd3; B = 4'd4; A = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gap = 1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || value !== 14'd12) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b done=%b value=%0d, expected 1 0 12",
                     busy, done, value);
        end
        while (done !== 1'b1 && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        checks++;
        if (gap !== 5 || value !== 14'd345) begin
            errors++;
            $display("FAIL b2b_second: gap=%0d value=%0d, expected 5 345", gap, value);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        int active;
        int n;
        start_conv(4'd1, 4'd1, 4'd1, 4'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (value !== 14'd0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: value=%0d busy=%b done=%b error=%b, expected 0 0 0 0",
                     value, busy, done, error);
        end
        @(negedge clk);
        rst = 1'b0;
        active = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) active++;
        end
        checks++;
        if (active !== 0) begin
            errors++;
            $display("FAIL reset_abort: got %0d active cycles expected 0", active);
        end
        start_conv(4'd0, 4'd0, 4'd0, 4'd7);
        wait_idle(n);
        checks++;
        if (done !== 1'b1 || value !== 14'd7 || n !== 4) begin
            errors++;
            $display("FAIL after_reset_conv: done=%b value=%0d lat=%0d, expected 1 7 4",
                     done, value, n);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_patterns();
        test_invalid();
        test_start_while_busy();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd4digit_to_bin.md
Name: bcd4digit_to_bin

Overview:
Sequential BCD-to-binary converter. It takes four BCD digits in the same A..D digit format the display path uses (A = ones, D = thousands, 4'hF = blank) and returns a 14-bit binary value. It is the inverse of the binary-to-BCD datapath: it accepts keypad or display digits and hands the binary value to control logic. It performs one multiply-by-10-and-add step per clock under a start/done handshake.

Parameters:
None. Digit count fixed at 4; output width fixed at 14 (max 9999 < 16383).

Ports:
clk    input   1   system clock, rising edge
rst    input   1   asynchronous reset, active-high
start  input   1   request conversion; sampled on rising clk edge
A      input   4   ones digit (BCD, 4'hF = blank)
B      input   4   tens digit
C      input   4   hundreds digit
D      input   4   thousands digit
value  output  14  converted binary result; held until next completion
busy   output  1   conversion in progress; start ignored while high
done   output  1   one-cycle pulse; value/error valid
error  output  1   set with done if any digit was 4'hA..4'hE; held until next completion

Behaviour:
- Reset (rst high, asynchronous): state=IDLE, value=0, busy=0, done=0, error=0, internal accumulator/digit latches/index=0. Reset mid-conversion aborts immediately; no done pulse follows.
- States: IDLE, CONV, DONE.
- IDLE/DONE + start=1 at edge N:
  - latch A..D into internal registers
  - acc<=0, ix<=3, state<=CONV
  - set internal bad flag if any latched digit is in 4'hA..4'hE
- CONV, one digit per edge, D first (ix=3 -> D, 2 -> C, 1 -> B, 0 -> A):
  - acc <= acc*10 + d, where acc*10 = (acc<<3)+(acc<<1), computed at 14+ bits with no overflow possible.
  - Blank (4'hF) contributes 0.
  - Invalid digits contribute 0; result is forced to 0 at completion.
  - ix decrements each edge.
- Completion, edge N+4 (processes ix=0):
  - value <= bad ? 0 : final acc
  - error <= bad
  - done <= 1, state <= DONE
- DONE, edge N+5:
  - done <= 0
  - state <= IDLE, unless start=1, in which case a new conversion begins exactly as from IDLE.
- Latency: start at edge N -> done high during cycle after edge N+4 (4 clocks). Back-to-back throughput: one conversion per 5 clocks.
- busy = 1 in CONV only; 0 in IDLE and DONE.
- start while busy: ignored, no queuing; inputs A..D may change freely during CONV (latched copies used).
- value and error change only at completion or reset; stable otherwise.
- done never asserts without a preceding accepted start.

Test Plan:
- Reset then start with D,C,B,A = 1,2,3,4 -> after 4 clocks done pulses 1 cycle, value=1234 (14'h04D2), error=0, busy high for exactly 4 cycles.
- Digits 9,9,9,9 -> value=9999 (14'h270F); digits 0,0,0,0 -> value=0, error=0.
- Blanks F,F,F,5 -> value=5; digits F,3,F,7 -> value=307.
- Invalid digit C=4'hB with others 1 -> done pulses, value=0, error=1. Next valid conversion 0,0,4,2 -> value=42, error=0.
- start re-pulsed every cycle during CONV and A..D changed mid-conversion -> single done after 4 clocks, value from digits latched at accepted start. start held in DONE cycle -> second conversion begins immediately, done pulses 5 clocks after the first.
- rst asserted asynchronously at cycle 2 of CONV -> value=0, busy=0, done=0 immediately; no done pulse after release until a new start.
